// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART TX scheduler slice.
//                - sched_state_t : scheduler state encoding (IDLE/GRANT/GUARD)
//                - MODE_W        : width of the opaque TX/RX mode word
//                - MODE_DEFAULT  : mode value the link comes up in
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int MODE_W = 4;
    localparam logic [MODE_W-1:0] MODE_DEFAULT = 4'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_pick
//  Description : Combinational round-robin picker. Finds the first set bit of
//                `valid` searching upward from rr_ptr+1, wrapping modulo N_REQ.
//  Ports       : valid  [N_REQ]  - candidate vector
//                rr_ptr [IDX_W]  - index served last
//                any             - at least one candidate present
//                idx    [IDX_W]  - selected index (0 when any==0)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // Walk the distances from farthest to nearest so the nearest valid
    // candidate after rr_ptr is the one left standing.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (valid[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Shares one UART transmitter between N_REQ packet requesters
//                (whole packets, round robin) and sequences mode changes,
//                which are applied only while the TX is idle and followed by
//                a guard interval of GUARD_CYCLES cycles.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                req_data/valid/last/ready - per-requester byte streams
//                mode_req_valid/mode_req/mode_req_ready - mode change channel
//                tx_data/tx_valid/tx_ready - byte handshake to the TX
//                tx_mode                  - mode to TX and RX
//                grant_id                 - current or last granted requester
//                busy                     - scheduler not in IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int                N_REQ        = 4,
    parameter int                GUARD_CYCLES = 16,
    parameter logic [MODE_W-1:0] MODE_RESET   = MODE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     mode_req_valid,
    input  logic [MODE_W-1:0]        mode_req,
    output logic                     mode_req_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [MODE_W-1:0]        tx_mode,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);

    localparam int c_IDX_W  = $clog2(N_REQ);
    localparam int c_GCNT_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [c_GCNT_W-1:0] c_GUARD_LOAD = c_GCNT_W'(GUARD_CYCLES - 1);

    sched_state_t          r_state;
    logic [c_IDX_W-1:0]    r_rr_ptr;
    logic [c_IDX_W-1:0]    r_grant_id;
    logic [MODE_W-1:0]     r_tx_mode;
    logic [c_GCNT_W-1:0]   r_guard_cnt;
    logic                  r_busy;

    logic                  w_pick_any;
    logic [c_IDX_W-1:0]    w_pick_idx;
    logic                  w_mode_take;
    logic [7:0]            w_tx_data;
    logic                  w_tx_valid;
    logic [N_REQ-1:0]      w_req_ready;
    logic                  w_last;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_pick (
        .valid  (req_valid),
        .rr_ptr (r_rr_ptr),
        .any    (w_pick_any),
        .idx    (w_pick_idx)
    );

    // TX handshake mux: only the granted requester sees tx_ready, and only
    // in GRANT. A mode request is taken only when no frame is in flight.
    always_comb begin
        w_tx_data   = 8'h00;
        w_tx_valid  = 1'b0;
        w_req_ready = '0;
        w_mode_take = 1'b0;
        w_last      = req_last[r_grant_id];
        case (r_state)
            IDLE: begin
                w_mode_take = mode_req_valid && tx_ready;
            end
            GRANT: begin
                w_tx_data               = req_data[{r_grant_id, 3'b000} +: 8];
                w_tx_valid              = req_valid[r_grant_id];
                w_req_ready[r_grant_id] = tx_ready;
            end
            default: begin
                w_tx_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= c_IDX_W'(N_REQ - 1);
            r_grant_id  <= '0;
            r_tx_mode   <= MODE_RESET;
            r_guard_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mode_take) begin
                        r_tx_mode   <= mode_req;
                        r_guard_cnt <= c_GUARD_LOAD;
                        r_state     <= GUARD;
                        r_busy      <= 1'b1;
                    end else if (!mode_req_valid && w_pick_any) begin
                        // A pending (blocked) mode request holds off data grants.
                        r_grant_id <= w_pick_idx;
                        r_state    <= GRANT;
                        r_busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    // Grant is held across requester stalls until `last` moves.
                    if (w_tx_valid && tx_ready && w_last) begin
                        r_rr_ptr <= r_grant_id;
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                    end
                end
                GUARD: begin
                    if (r_guard_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_guard_cnt <= r_guard_cnt - c_GCNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = w_req_ready;
    assign mode_req_ready = w_mode_take;
    assign tx_data        = w_tx_data;
    assign tx_valid       = w_tx_valid;
    assign tx_mode        = r_tx_mode;
    assign grant_id       = r_grant_id;
    assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_sched
//  Description : Self-checking bench for uart_tx_sched: a table of IDLE
//                decisions from reset, hand-written packet sequences, and a
//                randomized run against a packet-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int N = 4;
    localparam int G = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           mode_req_valid;
    logic [3:0]     mode_req;
    logic           mode_req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [3:0]     tx_mode;
    logic [1:0]     grant_id;
    logic           busy;

    uart_tx_sched #(
        .N_REQ        (N),
        .GUARD_CYCLES (G),
        .MODE_RESET   (4'd1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_data       (req_data),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .mode_req_valid (mode_req_valid),
        .mode_req       (mode_req),
        .mode_req_ready (mode_req_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_mode        (tx_mode),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-requester packet queues (ring buffers) driven onto the byte ports.
    logic [7:0] pk_d [N][64];
    bit         pk_l [N][64];
    int         rd [N];
    int         wr [N];
    bit         hold [N];

    task automatic push_pkt(input int i, input int len, input logic [7:0] b0, input bit rnd);
        for (int k = 0; k < len; k++) begin
            pk_d[i][wr[i] % 64] = rnd ? 8'($urandom) : b0 + 8'(k);
            pk_l[i][wr[i] % 64] = (k == len - 1);
            wr[i]++;
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            if (wr[i] != rd[i]) begin
                req_data[i*8 +: 8] = pk_d[i][rd[i] % 64];
                req_last[i]        = pk_l[i][rd[i] % 64];
                req_valid[i]       = !hold[i];
            end else begin
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
                req_valid[i]       = 1'b0;
            end
        end
    endtask

    // Reference model: who owns the TX (-1 = nobody), guard cycles left,
    // current mode, last served requester, last granted requester.
    int         m_owner;
    int         m_guard;
    logic [3:0] m_mode;
    int         m_last;
    int         m_grant;

    task automatic model_reset();
        m_owner = -1;
        m_guard = 0;
        m_mode  = 4'd1;
        m_last  = N - 1;
        m_grant = 0;
    endtask

    // Observation logs (DUT side) and per-cycle snapshots.
    int         log_g[$];
    int         log_d[$];
    int         log_c[$];
    int         cyc;
    int         mrr_cyc;
    int         n_busy, n_mrr, n_txv, n_g2, n_rr0;
    logic       s_busy, s_txv;
    logic [3:0] s_mode;

    function automatic int at_q(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            rd[i] = 0;
            wr[i] = 0;
            hold[i] = 1'b0;
        end
        mode_req_valid = 1'b0;
        mode_req       = 4'h0;
        tx_ready       = 1'b0;
        rst            = 1'b1;
        apply_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        log_g.delete();
        log_d.delete();
        log_c.delete();
        cyc = 0; mrr_cyc = -1;
        n_busy = 0; n_mrr = 0; n_txv = 0; n_g2 = 0; n_rr0 = 0;
    endtask

    // One clock: compare DUT outputs with the model, advance the model,
    // then retire accepted bytes / mode requests on the bench side.
    task automatic cycle();
        logic [N-1:0] e_rr;
        logic [N-1:0] acc;
        logic         e_mrr, e_txv, macc;
        logic [7:0]   e_txd;
        bit           idle, found;
        int           j;
        @(negedge clk);
        idle  = (m_owner < 0) && (m_guard == 0);
        e_mrr = idle && mode_req_valid && tx_ready;
        e_txv = 1'b0;
        e_txd = 8'h00;
        e_rr  = '0;
        if (m_owner >= 0) begin
            e_txv          = req_valid[m_owner];
            e_txd          = req_data[m_owner*8 +: 8];
            e_rr[m_owner]  = tx_ready;
        end
        chk("req_ready",      32'(req_ready),      32'(e_rr));
        chk("mode_req_ready", 32'(mode_req_ready), 32'(e_mrr));
        chk("tx_valid",       32'(tx_valid),       32'(e_txv));
        chk("tx_data",        32'(tx_data),        32'(e_txd));
        chk("tx_mode",        32'(tx_mode),        32'(m_mode));
        chk("grant_id",       32'(grant_id),       32'(m_grant));
        chk("busy",           32'(busy),           32'(!idle));

        s_busy = busy; s_txv = tx_valid; s_mode = tx_mode;
        n_busy += int'(busy);
        n_mrr  += int'(mode_req_ready);
        n_txv  += int'(tx_valid);
        n_g2   += int'(grant_id == 2'd2);
        n_rr0  += int'(req_ready[0]);
        if (mode_req_ready && mrr_cyc < 0) mrr_cyc = cyc;
        if (tx_valid && tx_ready) begin
            log_g.push_back(int'(grant_id));
            log_d.push_back(int'(tx_data));
            log_c.push_back(cyc);
        end

        acc  = e_rr & req_valid;
        macc = e_mrr;
        if (rst) begin
            model_reset();
        end else if (m_owner >= 0) begin
            if (e_txv && tx_ready && req_last[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (m_guard > 0) begin
            m_guard--;
        end else if (e_mrr) begin
            m_mode  = mode_req;
            m_guard = G;
        end else if (!mode_req_valid && req_valid != '0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (!found && req_valid[j]) begin
                    found   = 1'b1;
                    m_owner = j;
                    m_grant = j;
                end
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) rd[i]++;
        end
        if (macc) mode_req_valid = 1'b0;
        apply_inputs();
    endtask

    typedef struct {
        logic [3:0] rv;
        logic       mrv;
        logic       txr;
        logic [3:0] mreq;
        logic       e_mrr;
        logic [1:0] e_gid;
        logic       e_busy;
        logic [3:0] e_mode;
    } vec_t;

    vec_t tbl [9];

    initial begin
        rst = 1'b1;
        req_data = '0; req_valid = '0; req_last = '0;
        mode_req_valid = 1'b0; mode_req = 4'h0; tx_ready = 1'b0;

        // IDLE decisions taken straight out of reset (rr_ptr = N-1).
        tbl[0] = '{4'b0000, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 4'h1};
        tbl[1] = '{4'b0001, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1, 4'h1};
        tbl[2] = '{4'b0100, 1'b0, 1'b0, 4'h0, 1'b0, 2'd2, 1'b1, 4'h1};
        tbl[3] = '{4'b1010, 1'b0, 1'b1, 4'h0, 1'b0, 2'd1, 1'b1, 4'h1};
        tbl[4] = '{4'b1000, 1'b0, 1'b1, 4'h0, 1'b0, 2'd3, 1'b1, 4'h1};
        tbl[5] = '{4'b1111, 1'b1, 1'b1, 4'h3, 1'b1, 2'd0, 1'b1, 4'h3};
        tbl[6] = '{4'b1111, 1'b1, 1'b0, 4'h3, 1'b0, 2'd0, 1'b0, 4'h1};
        tbl[7] = '{4'b0000, 1'b1, 1'b1, 4'hF, 1'b1, 2'd0, 1'b1, 4'hF};
        tbl[8] = '{4'b0110, 1'b1, 1'b1, 4'h0, 1'b1, 2'd0, 1'b1, 4'h0};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset tx_mode", 32'(tx_mode), 32'd1);
        chk("reset tx_valid", 32'(tx_valid), 32'd0);
        chk("reset tx_data", 32'(tx_data), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset grant_id", 32'(grant_id), 32'd0);

        for (int v = 0; v < 9; v++) begin
            do_reset();
            req_valid      = tbl[v].rv;
            req_last       = tbl[v].rv;
            req_data       = '0;
            mode_req_valid = tbl[v].mrv;
            mode_req       = tbl[v].mreq;
            tx_ready       = tbl[v].txr;
            @(negedge clk);
            chk($sformatf("tbl%0d mode_req_ready", v), 32'(mode_req_ready), 32'(tbl[v].e_mrr));
            @(posedge clk);
            #1;
            mode_req_valid = 1'b0;
            req_valid      = '0;
            @(negedge clk);
            chk($sformatf("tbl%0d grant_id", v), 32'(grant_id), 32'(tbl[v].e_gid));
            chk($sformatf("tbl%0d busy", v), 32'(busy), 32'(tbl[v].e_busy));
            chk($sformatf("tbl%0d tx_mode", v), 32'(tx_mode), 32'(tbl[v].e_mode));
        end

        // Single requester, 3-byte packet, tx_ready pulsing once per frame.
        do_reset();
        push_pkt(0, 3, 8'h41, 1'b0);
        apply_inputs();
        for (int c = 0; c < 12; c++) begin
            tx_ready = (c % 3 == 1);
            cycle();
        end
        chk("single bytes", 32'(log_d.size()), 32'd3);
        chk("single b0", 32'(at_q(log_d, 0)), 32'h41);
        chk("single b1", 32'(at_q(log_d, 1)), 32'h42);
        chk("single b2", 32'(at_q(log_d, 2)), 32'h43);
        chk("single ready pulses", 32'(n_rr0), 32'd3);
        chk("single idle after", 32'(s_busy), 32'd0);

        // Fairness: every requester streams 2-byte packets back to back.
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            push_pkt(i, 2, 8'(16*i), 1'b0);
            push_pkt(i, 2, 8'(16*i + 8), 1'b0);
        end
        apply_inputs();
        repeat (25) cycle();
        begin
            int exp_order [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
            for (int k = 0; k < 10; k++)
                chk($sformatf("fair order %0d", k), 32'(at_q(log_g, k)), 32'(exp_order[k]));
        end

        // Mode request raised in the middle of req1's packet.
        do_reset();
        tx_ready = 1'b1;
        push_pkt(1, 4, 8'h10, 1'b0);
        apply_inputs();
        cycle();
        cycle();
        mode_req_valid = 1'b1;
        mode_req       = 4'h3;
        push_pkt(0, 1, 8'h20, 1'b0);
        apply_inputs();
        repeat (30) cycle();
        chk("mode after last", 32'(mrr_cyc), 32'(at_q(log_c, 3) + 1));
        chk("mode pkt whole", 32'(at_q(log_g, 3)), 32'd1);
        chk("mode guard gap", 32'(at_q(log_c, 4) - mrr_cyc), 32'(G + 2));
        chk("mode next grant", 32'(at_q(log_g, 4)), 32'd0);
        chk("mode value", 32'(s_mode), 32'h3);

        // Mode request blocked while the TX line is busy.
        do_reset();
        tx_ready       = 1'b0;
        mode_req_valid = 1'b1;
        mode_req       = 4'h9;
        push_pkt(0, 1, 8'h55, 1'b0);
        apply_inputs();
        repeat (6) cycle();
        chk("blocked busy", 32'(n_busy), 32'd0);
        chk("blocked accept", 32'(n_mrr), 32'd0);
        tx_ready = 1'b1;
        cycle();
        chk("unblocked accept", 32'(n_mrr), 32'd1);
        repeat (G + 3) cycle();
        chk("unblocked mode", 32'(s_mode), 32'h9);
        chk("unblocked data", 32'(at_q(log_d, 0)), 32'h55);

        // Granted req2 stalls mid-packet while req0 waits.
        do_reset();
        tx_ready = 1'b1;
        push_pkt(2, 3, 8'hA0, 1'b0);
        apply_inputs();
        cycle();
        cycle();
        hold[2] = 1'b1;
        push_pkt(0, 1, 8'hB0, 1'b0);
        apply_inputs();
        n_txv = 0; n_g2 = 0;
        repeat (5) cycle();
        chk("stall tx_valid", 32'(n_txv), 32'd0);
        chk("stall grant held", 32'(n_g2), 32'd5);
        hold[2] = 1'b0;
        apply_inputs();
        repeat (8) cycle();
        chk("stall order 2", 32'(at_q(log_g, 2)), 32'd2);
        chk("stall order 3", 32'(at_q(log_g, 3)), 32'd0);
        chk("stall req0 byte", 32'(at_q(log_d, 3)), 32'hB0);

        // Reset in the middle of a granted packet, after a mode change.
        do_reset();
        tx_ready       = 1'b1;
        mode_req_valid = 1'b1;
        mode_req       = 4'h5;
        apply_inputs();
        repeat (G + 2) cycle();
        push_pkt(1, 3, 8'hC0, 1'b0);
        apply_inputs();
        cycle();
        cycle();
        rst = 1'b1;
        tx_ready = 1'b0;
        apply_inputs();
        cycle();
        rst = 1'b0;
        tx_ready = 1'b1;
        push_pkt(0, 1, 8'hD0, 1'b0);
        apply_inputs();
        cycle();
        chk("post-rst busy", 32'(s_busy), 32'd0);
        chk("post-rst tx_mode", 32'(s_mode), 32'd1);
        chk("post-rst tx_valid", 32'(s_txv), 32'd0);
        repeat (4) cycle();
        chk("post-rst first grant", 32'(at_q(log_g, 1)), 32'd0);
        chk("post-rst first byte", 32'(at_q(log_d, 1)), 32'hD0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (wr[i] == rd[i] && $urandom_range(0, 5) == 0)
                    push_pkt(i, int'($urandom_range(1, 4)), 8'h00, 1'b1);
                hold[i] = ($urandom_range(0, 4) == 0);
            end
            if (!mode_req_valid && $urandom_range(0, 40) == 0) begin
                mode_req_valid = 1'b1;
                mode_req       = 4'($urandom);
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 499) == 0);
            apply_inputs();
            cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
